// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the execute bus, completes word
// loads through a variable-latency rvalid handshake, raises a stall request
// while load data is outstanding, and drives the write-back and decode
// forwarding buses.
//
// Handshake: the SRAM asserts data_sram_rvalid for one or more cycles with
// data_sram_rdata valid in those cycles. The stage accepts the first rvalid
// seen in WAIT and ignores it in IDLE and HOLD. No ready signal is returned.
// The load result is only exposed with rf_we set once its data is available.
module mem_stage #(
  parameter int EX_TO_MEM_WD = 76,
  parameter int MEM_TO_WB_WD = 70,
  parameter int MEM_TO_ID_WD = 38,
  parameter int STALL_WD     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  input  logic                    data_sram_rvalid,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus,
  output logic                    stallreq_mem,
  output logic [1:0]              state_dbg
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [EX_TO_MEM_WD-1:0] r;
  logic [EX_TO_MEM_WD-1:0] r_next;
  logic                    r_write;
  logic                    bubble;
  logic                    advance;
  logic                    next_is_load;

  logic [1:0]  state;
  logic [31:0] hold_data;

  // Fields of the registered execute bus
  logic [31:0] r_pc;
  logic        r_ram_en;
  logic [3:0]  r_ram_wen;
  logic        r_sel_rf_res;
  logic        r_rf_we;
  logic [4:0]  r_rf_waddr;
  logic [31:0] r_ex_result;

  logic        is_load;
  logic        data_ok;
  logic [31:0] load_data;
  logic [31:0] rf_wdata;
  logic        rf_we_out;

  // Only stall bits 3 and 4 concern this stage.
  logic unused_stall;
  assign unused_stall = ^{stall[STALL_WD-1:5], stall[2:0]};

  assign r_pc         = r[75:44];
  assign r_ram_en     = r[43];
  assign r_ram_wen    = r[42:39];
  assign r_sel_rf_res = r[38];
  assign r_rf_we      = r[37];
  assign r_rf_waddr   = r[36:32];
  assign r_ex_result  = r[31:0];

  // Decide whether the input register changes this edge and with what
  always_comb begin
    bubble  = stall[3] & ~stall[4];
    advance = ~stall[3];
    r_write = bubble | advance;
    r_next  = bubble ? '0 : ex_to_mem_bus;
    // A bubble writes zero, which is never a load.
    next_is_load = r_next[43] & (r_next[42:39] == 4'b0) & r_next[38];
  end

  // Input register: bubble beats advance, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r <= '0;
    end else if (r_write) begin
      r <= r_next;
    end
  end

  // Load-completion FSM and captured load data
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold_data <= '0;
    end else if (r_write) begin
      state <= next_is_load ? WAIT : IDLE;
    end else if ((state == WAIT) && data_sram_rvalid) begin
      state     <= HOLD;
      hold_data <= data_sram_rdata;
    end
  end

  // Load status, result selection and output buses
  always_comb begin
    is_load      = r_ram_en & (r_ram_wen == 4'b0) & r_sel_rf_res;
    load_data    = (state == HOLD) ? hold_data : data_sram_rdata;
    data_ok      = ~is_load | (state == HOLD) | ((state == WAIT) & data_sram_rvalid);
    stallreq_mem = is_load & (state == WAIT) & ~data_sram_rvalid;
    rf_wdata     = r_sel_rf_res ? load_data : r_ex_result;
    rf_we_out    = r_rf_we & data_ok;
  end

  assign mem_to_wb_bus = {r_pc, rf_we_out, r_rf_waddr, rf_wdata};
  assign mem_to_id_bus = {rf_we_out, r_rf_waddr, rf_wdata};
  assign state_dbg     = state;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, ALU pass-through, zero-wait and
// multi-cycle loads, hold under freeze, bubble, reset mid-wait, and a
// spurious rvalid with a store in the stage.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic [75:0] ex_to_mem_bus;
  logic [31:0] data_sram_rdata;
  logic        data_sram_rvalid;
  logic [69:0] mem_to_wb_bus;
  logic [37:0] mem_to_id_bus;
  logic        stallreq_mem;
  logic [1:0]  state_dbg;

  int n_vec = 0;
  int n_bad = 0;

  mem_stage dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .ex_to_mem_bus    (ex_to_mem_bus),
    .data_sram_rdata  (data_sram_rdata),
    .data_sram_rvalid (data_sram_rvalid),
    .mem_to_wb_bus    (mem_to_wb_bus),
    .mem_to_id_bus    (mem_to_id_bus),
    .stallreq_mem     (stallreq_mem),
    .state_dbg        (state_dbg)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [75:0] ex_bus(input logic [31:0] pc, input logic ram_en,
                                         input logic [3:0] wen, input logic sel,
                                         input logic we, input logic [4:0] waddr,
                                         input logic [31:0] res);
    return {pc, ram_en, wen, sel, we, waddr, res};
  endfunction

  function automatic logic [69:0] wb_bus(input logic [31:0] pc, input logic we,
                                         input logic [4:0] waddr, input logic [31:0] data);
    return {pc, we, waddr, data};
  endfunction

  function automatic logic [69:0] id_bus(input logic we, input logic [4:0] waddr,
                                         input logic [31:0] data);
    return {32'h0, we, waddr, data};
  endfunction

  // driver task: advance one clock and settle past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    stall = '0;
    ex_to_mem_bus = '0;
    data_sram_rdata = '0;
    data_sram_rvalid = 1'b0;

    // Reset
    tick();
    check("rst_wb", mem_to_wb_bus, 70'h0);
    tick();
    rst = 1'b0;
    tick();
    check("idle_wb", mem_to_wb_bus, 70'h0);
    check("idle_id", {32'h0, mem_to_id_bus}, 70'h0);
    check("idle_stallreq", {69'h0, stallreq_mem}, 70'h0);
    check("idle_state", {68'h0, state_dbg}, 70'h0);

    // ALU pass-through
    ex_to_mem_bus = ex_bus(32'hBFC00010, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'h1234);
    tick();
    ex_to_mem_bus = '0;
    #1;
    check("alu_wb", mem_to_wb_bus, wb_bus(32'hBFC00010, 1'b1, 5'd5, 32'h1234));
    check("alu_id", {32'h0, mem_to_id_bus}, id_bus(1'b1, 5'd5, 32'h1234));

    // Zero-wait load
    ex_to_mem_bus = ex_bus(32'hBFC00014, 1'b1, 4'h0, 1'b1, 1'b1, 5'd8, 32'h100);
    tick();
    ex_to_mem_bus = '0;
    data_sram_rvalid = 1'b1;
    data_sram_rdata = 32'hDEADBEEF;
    #1;
    check("zw_stallreq", {69'h0, stallreq_mem}, 70'h0);
    check("zw_wb", mem_to_wb_bus, wb_bus(32'hBFC00014, 1'b1, 5'd8, 32'hDEADBEEF));
    check("zw_id", {32'h0, mem_to_id_bus}, id_bus(1'b1, 5'd8, 32'hDEADBEEF));
    tick();
    data_sram_rvalid = 1'b0;
    data_sram_rdata = '0;

    // 3-cycle load
    ex_to_mem_bus = ex_bus(32'hBFC00018, 1'b1, 4'h0, 1'b1, 1'b1, 5'd9, 32'h200);
    tick();
    ex_to_mem_bus = '0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("l3_stallreq", {69'h0, stallreq_mem}, 70'h1);
      check("l3_wb_we", {69'h0, mem_to_wb_bus[37]}, 70'h0);
      check("l3_id_we", {69'h0, mem_to_id_bus[37]}, 70'h0);
      check("l3_state", {68'h0, state_dbg}, 70'h1);
      stall = 6'b011111;
      tick();
    end
    stall = '0;
    data_sram_rvalid = 1'b1;
    data_sram_rdata = 32'hCAFE0001;
    #1;
    check("l3_done_stallreq", {69'h0, stallreq_mem}, 70'h0);
    check("l3_done_wb", mem_to_wb_bus, wb_bus(32'hBFC00018, 1'b1, 5'd9, 32'hCAFE0001));
    check("l3_done_id", {32'h0, mem_to_id_bus}, id_bus(1'b1, 5'd9, 32'hCAFE0001));
    tick();
    data_sram_rvalid = 1'b0;
    data_sram_rdata = '0;

    // Hold under external freeze
    ex_to_mem_bus = ex_bus(32'hBFC00020, 1'b1, 4'h0, 1'b1, 1'b1, 5'd10, 32'h300);
    tick();
    ex_to_mem_bus = ex_bus(32'hBFC00024, 1'b0, 4'h0, 1'b0, 1'b1, 5'd11, 32'h7777);
    stall = 6'b011111;
    data_sram_rvalid = 1'b1;
    data_sram_rdata = 32'h55AA55AA;
    #1;
    check("hold_first_wb", mem_to_wb_bus, wb_bus(32'hBFC00020, 1'b1, 5'd10, 32'h55AA55AA));
    tick();
    for (int i = 0; i < 3; i++) begin
      data_sram_rdata = 32'h12345670 + i;
      data_sram_rvalid = (i == 1);
      #1;
      check("hold_state", {68'h0, state_dbg}, 70'h2);
      check("hold_stallreq", {69'h0, stallreq_mem}, 70'h0);
      check("hold_wb", mem_to_wb_bus, wb_bus(32'hBFC00020, 1'b1, 5'd10, 32'h55AA55AA));
      check("hold_id", {32'h0, mem_to_id_bus}, id_bus(1'b1, 5'd10, 32'h55AA55AA));
      tick();
    end
    data_sram_rvalid = 1'b0;
    stall = '0;
    tick();
    ex_to_mem_bus = '0;
    #1;
    check("after_hold_wb", mem_to_wb_bus, wb_bus(32'hBFC00024, 1'b1, 5'd11, 32'h7777));

    // Bubble
    ex_to_mem_bus = ex_bus(32'hBFC00028, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'h0BAD);
    tick();
    check("pre_bubble_wb", mem_to_wb_bus, wb_bus(32'hBFC00028, 1'b1, 5'd3, 32'h0BAD));
    stall = 6'b001000;
    ex_to_mem_bus = ex_bus(32'hBFC0002C, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4, 32'h4444);
    tick();
    check("bubble_wb", mem_to_wb_bus, 70'h0);
    check("bubble_id", {32'h0, mem_to_id_bus}, 70'h0);
    stall = '0;
    ex_to_mem_bus = '0;

    // Reset mid-WAIT, then a late rvalid
    ex_to_mem_bus = ex_bus(32'hBFC00040, 1'b1, 4'h0, 1'b1, 1'b1, 5'd12, 32'h400);
    tick();
    ex_to_mem_bus = '0;
    stall = 6'b011111;
    #1;
    check("rw_stallreq_pre", {69'h0, stallreq_mem}, 70'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stall = '0;
    #1;
    check("rw_stallreq", {69'h0, stallreq_mem}, 70'h0);
    check("rw_state", {68'h0, state_dbg}, 70'h0);
    check("rw_wb", mem_to_wb_bus, 70'h0);
    data_sram_rvalid = 1'b1;
    data_sram_rdata = 32'hA5A5A5A5;
    tick();
    data_sram_rvalid = 1'b0;
    #1;
    check("late_rvalid_state", {68'h0, state_dbg}, 70'h0);
    check("late_rvalid_wb", mem_to_wb_bus, 70'h0);

    // Spurious rvalid with a store in the stage
    ex_to_mem_bus = ex_bus(32'hBFC00030, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'hABCD);
    tick();
    ex_to_mem_bus = '0;
    data_sram_rvalid = 1'b1;
    data_sram_rdata = 32'hFFFFFFFF;
    #1;
    check("store_stallreq", {69'h0, stallreq_mem}, 70'h0);
    check("store_wb", mem_to_wb_bus, wb_bus(32'hBFC00030, 1'b0, 5'd0, 32'hABCD));
    check("store_state", {68'h0, state_dbg}, 70'h0);
    tick();
    data_sram_rvalid = 1'b0;
    #1;
    check("post_store_wb", mem_to_wb_bus, 70'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
